// File: rtl/envelope_sample_scaler.sv
// -----------------------------------------------------------------------------
// envelope_sample_scaler
//
// Applies the envelope attenuation from the decay shift stage to a signed
// sample stream. The applied shift (cur_shift) glides one step toward
// shift_amount per accepted sample, which avoids zipper noise. One output
// sample is buffered behind a valid/ready handshake, so the block has
// 1-cycle latency and full throughput.
//
// Optional build macro: SCALER_ROUNDING_EN
//   defined     : out = (in + 2^(s-1)) >>> s for s > 0, rounding half toward
//                 +inf, with saturation to the positive full-scale value
//   not defined : plain arithmetic shift (rounds toward -inf), no adder
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-high reset, clears all state
//   mute         in   forces out_sample=0 and full attenuation on accept
//   shift_amount in   target attenuation
//   done         in   decay shift stage has reached its target
//   in_sample    in   signed input sample
//   in_valid     in   in_sample valid
//   in_ready     out  scaler can accept in_sample this cycle
//   out_sample   out  attenuated signed sample
//   out_valid    out  out_sample valid
//   out_ready    in   downstream accepts out_sample this cycle
//   cur_shift    out  shift currently applied
//   settled      out  registered: done && cur_shift == shift_amount && !mute
// -----------------------------------------------------------------------------
module envelope_sample_scaler #(
    parameter int DATA_W  = 16,
    parameter int SHIFT_W = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mute,
    input  logic [SHIFT_W-1:0]       shift_amount,
    input  logic                     done,
    input  logic signed [DATA_W-1:0] in_sample,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_sample,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SHIFT_W-1:0]       cur_shift,
    output logic                     settled
);

    localparam logic [SHIFT_W-1:0] SHIFT_MAX = '1;

    logic                     accept;
    logic signed [DATA_W-1:0] scaled;
    logic [SHIFT_W-1:0]       next_shift;

    // The output register can take a new sample whenever it is empty or
    // is being drained this same cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef SCALER_ROUNDING_EN
    // One extra bit of headroom so the rounding add cannot wrap.
    localparam logic signed [DATA_W:0] SAT_MAX = (DATA_W+1)'((2 ** (DATA_W-1)) - 1);

    logic signed [DATA_W:0] wide;
    logic signed [DATA_W:0] rnd;
    logic signed [DATA_W:0] sum;
    logic signed [DATA_W:0] shifted;

    always_comb begin
        wide    = {in_sample[DATA_W-1], in_sample};
        rnd     = '0;
        sum     = wide;
        shifted = wide;
        scaled  = in_sample;
        if (cur_shift != '0) begin
            rnd     = $signed({{DATA_W{1'b0}}, 1'b1} << (cur_shift - 1'b1));
            sum     = wide + rnd;
            shifted = sum >>> cur_shift;
            if (shifted > SAT_MAX)
                scaled = SAT_MAX[DATA_W-1:0];
            else
                scaled = $signed(shifted[DATA_W-1:0]);
        end
    end
`else
    always_comb begin
        scaled = in_sample >>> cur_shift;
    end
`endif

    // Glide one step toward the target; mute jumps straight to full
    // attenuation. The target never exceeds SHIFT_MAX, so steps cannot wrap.
    always_comb begin
        next_shift = cur_shift;
        if (mute)
            next_shift = SHIFT_MAX;
        else if (cur_shift < shift_amount)
            next_shift = cur_shift + 1'b1;
        else if (cur_shift > shift_amount)
            next_shift = cur_shift - 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_sample <= '0;
            out_valid  <= 1'b0;
            cur_shift  <= '0;
            settled    <= 1'b0;
        end else begin
            if (accept) begin
                // A simultaneous handoff and accept simply overwrites the
                // register, so out_valid stays high with no bubble.
                out_sample <= mute ? '0 : scaled;
                out_valid  <= 1'b1;
                cur_shift  <= next_shift;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end
            settled <= done && (cur_shift == shift_amount) && !mute;
        end
    end

endmodule

// File: tb/tb_envelope_sample_scaler.sv
module tb_envelope_sample_scaler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mute = 1'b0;
    logic [3:0]  shift_amount = 4'd0;
    logic        done = 1'b1;
    logic [15:0] in_sample = 16'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_sample;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  cur_shift;
    logic        settled;

`ifdef SCALER_ROUNDING_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];

    envelope_sample_scaler #(.DATA_W(16), .SHIFT_W(4)) dut (
        .clock(clock), .reset(reset), .mute(mute), .shift_amount(shift_amount),
        .done(done), .in_sample(in_sample), .in_valid(in_valid), .in_ready(in_ready),
        .out_sample(out_sample), .out_valid(out_valid), .out_ready(out_ready),
        .cur_shift(cur_shift), .settled(settled)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        mute;
        logic [3:0]  amt;
        logic [15:0] smp;
        logic [15:0] exp_out;
        logic [3:0]  exp_shift;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive a sample until it is accepted; the expected output is queued at
    // the negedge before the accepting edge.
    task automatic send(input logic [15:0] s, input logic [15:0] e);
        bit ok = 1'b0;
        in_sample = s;
        in_valid  = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clock);
            if (in_ready) begin
                exp_q.push_back(e);
                ok = 1'b1;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout sample=%0h never accepted", s);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Scoreboard: an output handshake completes at the next posedge.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_unexpected got=%0h expected=none", out_sample);
            end else begin
                check("out_sample", {16'h0, out_sample}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        //           mute  amt    in        out       shift after
        vecs[0]  = '{1'b0, 4'd0,  16'h4000, 16'h4000, 4'd0};
        vecs[1]  = '{1'b0, 4'd3,  16'h4000, 16'h4000, 4'd1};
        vecs[2]  = '{1'b0, 4'd3,  16'h4000, 16'h2000, 4'd2};
        vecs[3]  = '{1'b0, 4'd3,  16'h4000, 16'h1000, 4'd3};
        vecs[4]  = '{1'b0, 4'd3,  16'h4000, 16'h0800, 4'd3};
        vecs[5]  = '{1'b0, 4'd3,  16'hC000, 16'hF800, 4'd3};
        vecs[6]  = '{1'b0, 4'd3,  16'hFFF8, 16'hFFFF, 4'd3};
        vecs[7]  = '{1'b1, 4'd3,  16'h7FFF, 16'h0000, 4'd15};
        vecs[8]  = '{1'b0, 4'd0,  16'h8000, 16'hFFFF, 4'd14};
        vecs[9]  = '{1'b0, 4'd0,  16'h4000, 16'h0001, 4'd13};
        vecs[10] = '{1'b0, 4'd0,  16'h6000, 16'h0003, 4'd12};
        vecs[11] = '{1'b0, 4'd15, 16'h8000, 16'hFFF8, 4'd13};
        vecs[12] = '{1'b0, 4'd15, 16'h8000, 16'hFFFC, 4'd14};
        vecs[13] = '{1'b0, 4'd15, 16'h8000, 16'hFFFE, 4'd15};
        vecs[14] = '{1'b0, 4'd15, 16'h8000, 16'hFFFF, 4'd15};

        // Reset state
        cycles(2);
        check("rst_out_valid", {31'h0, out_valid}, 0);
        check("rst_out_sample", {16'h0, out_sample}, 0);
        check("rst_cur_shift", {28'h0, cur_shift}, 0);
        check("rst_settled", {31'h0, settled}, 0);
        check("rst_in_ready", {31'h0, in_ready}, 1);
        reset = 1'b0;
        cycles(1);

        // Glide, mute, saturation and shift-15 boundaries
        foreach (vecs[i]) begin
            mute = vecs[i].mute;
            shift_amount = vecs[i].amt;
            send(vecs[i].smp, vecs[i].exp_out);
            check($sformatf("vec%0d_cur_shift", i), {28'h0, cur_shift}, {28'h0, vecs[i].exp_shift});
        end
        mute = 1'b0;
        cycles(2);

        // settled: cur_shift == 15 == shift_amount, done=1
        check("settled_hi", {31'h0, settled}, 1);
        mute = 1'b1;
        cycles(2);
        check("settled_mute", {31'h0, settled}, 0);
        check("mute_no_accept_shift", {28'h0, cur_shift}, 15);
        mute = 1'b0;
        done = 1'b0;
        cycles(2);
        check("settled_not_done", {31'h0, settled}, 0);
        done = 1'b1;
        cycles(2);
        check("settled_again", {31'h0, settled}, 1);

        // Backpressure: hold, then release with no loss or duplication
        reset = 1'b1;
        exp_q.delete();
        cycles(1);
        reset = 1'b0;
        shift_amount = 4'd0;
        cycles(1);
        out_ready = 1'b0;
        send(16'h1111, 16'h1111);
        fork
            send(16'h2222, 16'h2222);
            begin
                repeat (3) begin
                    @(negedge clock);
                    check("bp_in_ready", {31'h0, in_ready}, 0);
                    check("bp_hold", {16'h0, out_sample}, 16'h1111);
                end
                @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join
        send(16'h3333, 16'h3333);
        cycles(3);
        check("bp_drained", exp_q.size(), 0);

        // Rounding at cur_shift=1
        shift_amount = 4'd1;
        send(16'h0100, 16'h0100);
        send(16'h0003, RND ? 16'h0002 : 16'h0001);
        send(16'h7FFF, RND ? 16'h4000 : 16'h3FFF);
        send(16'hFFFD, RND ? 16'hFFFF : 16'hFFFE);
        check("rnd_cur_shift", {28'h0, cur_shift}, 1);
        cycles(3);
        check("rnd_drained", exp_q.size(), 0);

        // Reset while a sample is held
        out_ready = 1'b0;
        send(16'h1234, 16'h1234);
        check("pre_rst_valid", {31'h0, out_valid}, 1);
        check("pre_rst_shift", {28'h0, cur_shift}, 1);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_valid", {31'h0, out_valid}, 0);
        check("mid_rst_shift", {28'h0, cur_shift}, 0);
        check("mid_rst_in_ready", {31'h0, in_ready}, 1);
        cycles(1);
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("post_rst_no_out", {31'h0, out_valid}, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
